// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - command codes and state encoding shared by the SPI flash responder
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [7:0] CMD_RDID = 8'h9F;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, STATUS, ID, IGNORE} state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - brings SCK/CS_n/MOSI into i_clk and derives one-cycle SCK edge strobes
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sck,
  input  logic i_cs_n,
  input  logic i_mosi,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_cs_n,
  output logic o_mosi
);

  localparam int L = SYNC_STAGES - 1;

  logic [L:0] sck_q;
  logic [L:0] cs_q;
  logic [L:0] mosi_q;
  logic       sck_prev;

  // CS_n resets to deselected so the responder wakes up idle
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sck_q    <= '0;
      cs_q     <= '1;
      mosi_q   <= '0;
      sck_prev <= 1'b0;
    end else begin
      sck_q    <= {sck_q[L-1:0], i_sck};
      cs_q     <= {cs_q[L-1:0], i_cs_n};
      mosi_q   <= {mosi_q[L-1:0], i_mosi};
      sck_prev <= sck_q[L];
    end
  end

  assign o_sck_rise = sck_q[L] & ~sck_prev;
  assign o_sck_fall = ~sck_q[L] & sck_prev;
  assign o_cs_n     = cs_q[L];
  assign o_mosi     = mosi_q[L];

endmodule

// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - SPI mode-0 serial flash target answering read, read-status and JEDEC-ID
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
  parameter int          AW          = 24,
  parameter int          SYNC_STAGES = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_spi_sck,
  input  logic          i_spi_cs_n,
  input  logic          i_spi_mosi,
  output logic          o_spi_miso,
  output logic          o_mem_req,
  output logic [AW-1:0] o_mem_addr,
  input  logic          i_mem_ack,
  input  logic [7:0]    i_mem_data,
  input  logic [7:0]    i_status,
  output logic          o_busy,
  output logic          o_underrun
);

  logic sck_rise, sck_fall, cs_n, mosi;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_sck      (i_spi_sck),
    .i_cs_n     (i_spi_cs_n),
    .i_mosi     (i_spi_mosi),
    .o_sck_rise (sck_rise),
    .o_sck_fall (sck_fall),
    .o_cs_n     (cs_n),
    .o_mosi     (mosi)
  );

  state_t      state;
  logic [2:0]  bitcnt;
  logic [1:0]  byte_cnt;      // address bytes in ADDR, byte index in ID
  logic [6:0]  rx_sr;
  logic [6:0]  tx_sr;         // bits still to shift out after the one on MISO
  logic [22:0] addr_sr;
  logic [7:0]  buf_data;
  logic        buf_valid;
  logic        load_pending;  // next SCK fall is a byte boundary
  logic [7:0]  rx_next;
  logic [23:0] addr_next;
  logic [7:0]  id_byte;

  assign rx_next   = {rx_sr, mosi};
  assign addr_next = {addr_sr, mosi};
  assign o_busy    = ~cs_n;

  always_comb begin
    id_byte = 8'hFF;
    case (byte_cnt)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      2'd2:    id_byte = JEDEC_ID[7:0];
      default: id_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      bitcnt       <= '0;
      byte_cnt     <= '0;
      rx_sr        <= '0;
      tx_sr        <= '1;
      addr_sr      <= '0;
      buf_data     <= '0;
      buf_valid    <= 1'b0;
      load_pending <= 1'b0;
      o_spi_miso   <= 1'b1;
      o_mem_req    <= 1'b0;
      o_mem_addr   <= '0;
      o_underrun   <= 1'b0;
    end else if (cs_n) begin
      state        <= IDLE;
      bitcnt       <= '0;
      buf_valid    <= 1'b0;
      load_pending <= 1'b0;
      o_spi_miso   <= 1'b1;
      o_mem_req    <= 1'b0;
      o_underrun   <= 1'b0;
    end else begin
      if (state == IDLE) state <= CMD;

      if (o_mem_req && i_mem_ack) begin
        buf_data  <= i_mem_data;
        buf_valid <= 1'b1;
        o_mem_req <= 1'b0;
      end

      if (sck_rise) begin
        rx_sr  <= rx_next[6:0];
        bitcnt <= bitcnt + 3'd1;
        if (bitcnt == 3'd7) load_pending <= 1'b1;
        case (state)
          IDLE, CMD: if (bitcnt == 3'd7) begin
            byte_cnt <= '0;
            case (rx_next)
              CMD_READ: state <= ADDR;
              CMD_RDSR: state <= STATUS;
              CMD_RDID: state <= ID;
              default:  state <= IGNORE;
            endcase
          end
          ADDR: begin
            addr_sr <= addr_next[22:0];
            if (bitcnt == 3'd7) begin
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd2) begin
                o_mem_addr <= addr_next[AW-1:0];
                o_mem_req  <= 1'b1;
                buf_valid  <= 1'b0;
                state      <= DATA;
              end
            end
          end
          default: ;
        endcase
      end

      if (sck_fall) begin
        load_pending <= 1'b0;
        if (load_pending) begin
          case (state)
            DATA: if (buf_valid) begin
              tx_sr      <= buf_data[6:0];
              o_spi_miso <= buf_data[7];
              buf_valid  <= 1'b0;
              o_mem_req  <= 1'b1;
              o_mem_addr <= o_mem_addr + AW'(1);
            end else begin
              // the late request stays outstanding; its byte goes out next boundary
              tx_sr      <= '1;
              o_spi_miso <= 1'b1;
              o_underrun <= 1'b1;
            end
            STATUS: begin
              tx_sr      <= i_status[6:0];
              o_spi_miso <= i_status[7];
            end
            ID: begin
              tx_sr      <= id_byte[6:0];
              o_spi_miso <= id_byte[7];
              if (byte_cnt != 2'd3) byte_cnt <= byte_cnt + 2'd1;
            end
            default: o_spi_miso <= 1'b1;
          endcase
        end else if (state == DATA || state == STATUS || state == ID) begin
          o_spi_miso <= tx_sr[6];
          tx_sr      <= {tx_sr[5:0], 1'b1};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb/tb_spi_flash_responder.sv - randomized self-checking bench for spi_flash_responder
module tb_spi_flash_responder;

  localparam int S = 2;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_spi_sck = 1'b0;
  logic        i_spi_cs_n = 1'b1;
  logic        i_spi_mosi = 1'b0;
  logic        o_spi_miso;
  logic        o_mem_req;
  logic [23:0] o_mem_addr;
  logic        i_mem_ack = 1'b0;
  logic [7:0]  i_mem_data = 8'h00;
  logic [7:0]  i_status = 8'h00;
  logic        o_busy;
  logic        o_underrun;

  int vectors = 0;
  int miscompares = 0;

  always #5 i_clk = ~i_clk;

  spi_flash_responder #(.JEDEC_ID(24'hEF4016), .AW(24), .SYNC_STAGES(S)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_spi_sck  (i_spi_sck),
    .i_spi_cs_n (i_spi_cs_n),
    .i_spi_mosi (i_spi_mosi),
    .o_spi_miso (o_spi_miso),
    .o_mem_req  (o_mem_req),
    .o_mem_addr (o_mem_addr),
    .i_mem_ack  (i_mem_ack),
    .i_mem_data (i_mem_data),
    .i_status   (i_status),
    .o_busy     (o_busy),
    .o_underrun (o_underrun)
  );

  int          ack_delay = 2;
  logic [7:0]  salt = 8'h00;
  logic [23:0] req_log[$];
  logic [7:0]  rd_q[$];
  logic [7:0]  cs_hist = '1;
  bit          mon_en = 1'b1;
  logic [23:0] jid = 24'hEF4016;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ salt;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // memory: logs each request, acks it ack_delay cycles later
  initial begin
    int  wait_cnt;
    bit  ack_done;
    wait_cnt = 0;
    ack_done = 0;
    forever begin
      @(negedge i_clk);
      i_mem_ack = 1'b0;
      if (o_mem_req && !ack_done) begin
        if (wait_cnt == 0) req_log.push_back(o_mem_addr);
        if (wait_cnt >= ack_delay - 1) begin
          i_mem_ack  = 1'b1;
          i_mem_data = mem_byte(o_mem_addr);
          ack_done   = 1;
        end else wait_cnt++;
      end else if (!o_mem_req) begin
        wait_cnt = 0;
        ack_done = 0;
      end
    end
  end

  // per-cycle checks: busy tracks CS_n after the synchronizer; deselected means idle outputs
  initial forever begin
    @(posedge i_clk);
    #1;
    cs_hist = {cs_hist[6:0], i_spi_cs_n};
    if (mon_en) begin
      chk("busy", o_busy, !cs_hist[S-1]);
      if (cs_hist[S]) begin
        chk("idle_miso", o_spi_miso, 1);
        chk("idle_req", o_mem_req, 0);
        chk("idle_underrun", o_underrun, 0);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time %0t exceeded bound", $time);
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic spi_bit(input logic b, output logic r);
    i_spi_mosi = b;
    wait_clk(4);
    r = o_spi_miso;
    i_spi_sck = 1'b1;
    wait_clk(4);
    i_spi_sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic cs_low();
    @(negedge i_clk);
    i_spi_cs_n = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_high();
    wait_clk(4);
    i_spi_cs_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic do_read(input logic [23:0] addr, input int n, input bit under);
    logic [7:0]  r;
    logic [23:0] a;
    req_log.delete();
    rd_q.delete();
    cs_low();
    spi_byte(8'h03, r);
    chk("cmd_miso", r, 8'hFF);
    for (int b = 2; b >= 0; b--) begin
      spi_byte(addr[b*8 +: 8], r);
      chk("addr_miso", r, 8'hFF);
    end
    for (int i = 0; i < n; i++) begin
      spi_byte(8'($urandom), r);
      rd_q.push_back(r);
      if (under && i == 0) chk("rd_underrun_byte", r, 8'hFF);
      else begin
        a = addr + 24'(under ? i - 1 : i);
        chk("rd_data", r, mem_byte(a));
      end
    end
    for (int i = 0; i < n - (under ? 1 : 0); i++) begin
      a = addr + 24'(i);
      if (i < req_log.size()) chk("req_addr", req_log[i], a);
      else chk("req_count", req_log.size(), i + 1);
    end
    chk("underrun_flag", o_underrun, under);
    cs_high();
    chk("underrun_cleared", o_underrun, 0);
  endtask

  task automatic do_status(input logic [7:0] st, input int n);
    logic [7:0] r;
    rd_q.delete();
    i_status = st;
    cs_low();
    spi_byte(8'h05, r);
    chk("rdsr_cmd_miso", r, 8'hFF);
    for (int i = 0; i < n; i++) begin
      spi_byte(8'($urandom), r);
      rd_q.push_back(r);
      chk("status", r, st);
    end
    cs_high();
  endtask

  task automatic do_id(input int n);
    logic [7:0] r;
    rd_q.delete();
    cs_low();
    spi_byte(8'h9F, r);
    chk("rdid_cmd_miso", r, 8'hFF);
    for (int i = 0; i < n; i++) begin
      spi_byte(8'($urandom), r);
      rd_q.push_back(r);
      chk("jedec", r, (i < 3) ? jid[8*(2-i) +: 8] : 8'hFF);
    end
    cs_high();
  endtask

  task automatic do_other(input logic [7:0] c, input int n);
    logic [7:0] r;
    req_log.delete();
    cs_low();
    for (int i = 0; i <= n; i++) begin
      spi_byte((i == 0) ? c : 8'($urandom), r);
      chk("ignore_miso", r, 8'hFF);
    end
    chk("ignore_no_req", req_log.size(), 0);
    cs_high();
  endtask

  initial begin
    logic [7:0] r;
    logic       rb;
    logic [7:0] c;

    wait_clk(2);
    chk("rst_miso", o_spi_miso, 1);
    chk("rst_req", o_mem_req, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_underrun", o_underrun, 0);
    i_reset = 1'b0;
    wait_clk(4);

    // plain read, mem[a] = a[7:0]^a[15:8]^a[23:16]
    do_read(24'h000100, 4, 0);
    chk("lit_rd0", rd_q[0], 8'h01);
    chk("lit_rd1", rd_q[1], 8'h00);
    chk("lit_rd2", rd_q[2], 8'h03);
    chk("lit_rd3", rd_q[3], 8'h02);
    chk("lit_ra3", req_log[3], 24'h000103);

    do_read(24'hFFFFFE, 4, 0);
    chk("lit_wrap_a0", req_log[0], 24'hFFFFFE);
    chk("lit_wrap_a1", req_log[1], 24'hFFFFFF);
    chk("lit_wrap_a2", req_log[2], 24'h000000);
    chk("lit_wrap_a3", req_log[3], 24'h000001);
    chk("lit_wrap_d1", rd_q[1], 8'hFF);

    do_status(8'hA5, 2);
    chk("lit_status1", rd_q[1], 8'hA5);

    do_id(4);
    chk("lit_id0", rd_q[0], 8'hEF);
    chk("lit_id1", rd_q[1], 8'h40);
    chk("lit_id2", rd_q[2], 8'h16);
    chk("lit_id3", rd_q[3], 8'hFF);

    ack_delay = 40;
    do_read(24'h000200, 3, 1);
    chk("lit_under1", rd_q[1], 8'h02);
    ack_delay = 2;

    // abort after 12 address bits, then a fresh read
    req_log.delete();
    cs_low();
    spi_byte(8'h03, r);
    spi_byte(8'h12, r);
    chk("abort_addr_miso", r, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      spi_bit(1'b1, rb);
      chk("abort_bit_miso", rb, 1);
    end
    cs_high();
    chk("abort_no_req", req_log.size(), 0);
    do_read(24'h00ABCD, 2, 0);

    do_other(8'h0B, 3);

    // asynchronous reset in the middle of a data byte
    ack_delay = 40;
    req_log.delete();
    cs_low();
    spi_byte(8'h03, r);
    spi_byte(8'h34, r);
    spi_byte(8'h56, r);
    spi_byte(8'h78, r);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, rb);
    chk("pre_rst_req", o_mem_req, 1);
    chk("pre_rst_addr", o_mem_addr, 24'h345678);
    chk("pre_rst_underrun", o_underrun, 1);
    mon_en = 1'b0;
    #3;
    i_reset = 1'b1;
    #1;
    chk("arst_miso", o_spi_miso, 1);
    chk("arst_req", o_mem_req, 0);
    chk("arst_addr", o_mem_addr, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_underrun", o_underrun, 0);
    wait_clk(2);
    i_spi_cs_n = 1'b1;
    wait_clk(2);
    i_reset = 1'b0;
    wait_clk(8);
    mon_en = 1'b1;
    ack_delay = 2;
    do_read(24'h000010, 2, 0);

    for (int t = 0; t < 12; t++) begin
      salt = 8'($urandom);
      case ($urandom_range(0, 3))
        0: begin
          ack_delay = $urandom_range(1, 3);
          do_read(24'($urandom), $urandom_range(1, 4), 0);
        end
        1: do_status(8'($urandom), $urandom_range(1, 3));
        2: do_id($urandom_range(1, 5));
        default: begin
          do c = 8'($urandom); while (c == 8'h03 || c == 8'h05 || c == 8'h9F);
          do_other(c, $urandom_range(1, 3));
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- Synthesizable SPI-flash target emulator: the responder end of the serial-flash read protocol the team's SPI flash controllers initiate.
- Oversamples an external SCK/CS_n/MOSI in the system clock domain and decodes read (8'h03), read-status (8'h05) and JEDEC-ID (8'h9F) commands.
- For reads, fetches bytes from a local memory port and serializes them MSB-first on MISO.
- Used as a flash stand-in for FPGA boot images and as a bench-side flash model for controller regression.

Parameters:
- JEDEC_ID, 24'hEF4016, value returned by 8'h9F, MSB first.
- AW, 24, memory address width; address bits above AW are ignored.
- SYNC_STAGES, 2, synchronizer depth on SCK/CS_n/MOSI (minimum 2).

Ports:
- i_clk  in  1  system clock; all logic is on its rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_spi_sck  in  1  SPI clock, asynchronous to i_clk, mode 0.
- i_spi_cs_n  in  1  chip select, active low.
- i_spi_mosi  in  1  serial data from the initiator.
- o_spi_miso  out  1  serial data to the initiator.
- o_mem_req  out  1  memory read request, held until ack.
- o_mem_addr  out  AW  byte address of the request.
- i_mem_ack  in  1  single-cycle ack; i_mem_data is valid on the same cycle.
- i_mem_data  in  8  returned byte.
- i_status  in  8  status byte returned for 8'h05.
- o_busy  out  1  high while CS_n is sampled low.
- o_underrun  out  1  sticky error: a byte was needed before memory acked; cleared on CS_n rise.

Behaviour:
- Reset values: o_spi_miso=1, o_mem_req=0, o_mem_addr=0, o_busy=0, o_underrun=0, state=IDLE.
- Synchronization:
  - SCK, CS_n and MOSI each pass through SYNC_STAGES flops.
  - rise/fall strobes are one i_clk wide, from the last two synchronized SCK samples.
  - Required: SCK high and low phases each ≥ SYNC_STAGES+2 i_clk periods, i.e. f_sck ≤ f_clk/8 at defaults.
- Bit engine:
  - On sck rise, MOSI is shifted into rx_sr[7:0] and bitcnt[2:0] increments (wraps 7→0).
  - On sck fall, the next MISO bit shifts out of tx_sr.
  - On the fall following bitcnt wrap, tx_sr loads the next byte and MISO shows its bit 7.
- CS_n sampled high, from any state:
  - state→IDLE, bitcnt=0, o_spi_miso=1, o_mem_req=0, o_underrun=0.
  - A memory ack arriving after this is ignored.
- States and transitions:
  - IDLE: CS_n low → CMD.
  - CMD: after 8 rises, decode rx_sr. 8'h03→ADDR; 8'h05→STATUS with tx_sr=i_status; 8'h9F→ID with tx_sr=JEDEC_ID[23:16]; any other value→IGNORE.
  - ADDR: 24 bits are shifted into addr_sr MSB first. On the 24th rise, o_mem_addr=addr_sr[AW-1:0] and o_mem_req=1 → DATA.
  - DATA, byte boundary (fall after bitcnt wrap, and the first fall after ADDR):
    - Prefetch buffer valid: tx_sr=buffer, then issue the next request at o_mem_addr+1, wrapping at 2^AW.
    - Buffer empty: tx_sr=8'hFF and o_underrun=1; the request in flight stays outstanding and its data is used at the next boundary.
    - On i_mem_ack: buffer=i_mem_data, o_mem_req=0.
  - STATUS: i_status is re-sampled at every byte boundary and repeats until CS_n rises.
  - ID: emits the three JEDEC_ID bytes, then 8'hFF until CS_n rises.
  - IGNORE: MISO=1; stays here until CS_n rises.
- MISO is 1 throughout CMD and ADDR.
- o_busy = synchronized CS_n inverted.
- CS_n rising mid-byte aborts cleanly; the next CS_n fall starts a fresh CMD.

Decomposition:
- Shared package spi_flash_pkg holds:
  - CMD_READ=8'h03, CMD_RDSR=8'h05, CMD_RDID=8'h9F;
  - the state enum {IDLE, CMD, ADDR, DATA, STATUS, ID, IGNORE}.
- One sub-module, spi_sync_edge: the synchronizer plus rise/fall strobe generator for SCK, and synchronizer only for CS_n and MOSI.

Test Plan:
- Read: f_sck=f_clk/8, memory acks in 2 cycles. Send 03 00 01 00, clock 32 bits → MISO gives mem[0x100..0x103]; o_mem_addr steps 0x100→0x103; o_underrun=0.
- Wrap: read at 24'hFFFFFE for 4 bytes → requests go to FFFFFE, FFFFFF, 000000, 000001.
- Status and ID:
  - 8'h05 with i_status=8'hA5, 16 bits clocked → A5 A5.
  - 8'h9F, 32 bits clocked → EF 40 16 FF.
- Underrun: memory ack delayed 40 cycles → first data byte reads FF and o_underrun=1; the second byte is the correct mem[addr]; CS_n rise clears o_underrun.
- Abort and unknown:
  - CS_n rises after 12 address bits → next 03 transaction reads correctly.
  - Command 8'h0B → MISO stays 1 and o_mem_req is never asserted.
- Reset: assert i_reset asynchronously mid-DATA → all outputs return to reset values immediately, before the next i_clk edge.
